// File: rtl/cpu_opponent_pkg.sv
// cpu_opponent shared definitions: FSM encodings,
// button bit indices and the LFSR feedback mask/step.
package cpu_opponent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_APPROACH    = 3'd1,
        ST_RETREAT     = 3'd2,
        ST_ATK_PRESS   = 3'd3,
        ST_ATK_RELEASE = 3'd4,
        ST_SHIELD      = 3'd5,
        ST_OVER        = 3'd6,
        ST_JUMP        = 3'd7
    } state_e;

    localparam int BTN_CENTER = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 4;
    localparam int BTN_ATTACK = 5;
    localparam int BTN_SHIELD = 6;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/cpu_opponent_lfsr16.sv
// lfsr16: 16-bit Galois LFSR, steps once per advance pulse.
// A nonzero seed keeps the sequence away from the all-zero lockup.
module lfsr16
    import cpu_opponent_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next value: step only when asked
    always_comb begin
        q_d = q_q;
        if (advance) begin
            q_d = lfsr_step(q_q);
        end
    end

    // State register, reloads the seed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cpu_opponent.sv
// cpu_opponent: computer player emitting p2 button vectors.
// Optional jump-on-threat behaviour enabled by defining CPU_JUMP_EN.
module cpu_opponent
    import cpu_opponent_pkg::*;
#(
    parameter int          DECISION_DIV = 2_500_000,
    parameter int          ATTACK_RANGE = 80,
    parameter int          ATTACK_HOLD  = 1_500_000,
    parameter int          SHIELD_HOLD  = 5_000_000,
    parameter int          LOW_HEALTH   = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] self_x,
    input  logic [9:0] opp_x,
    input  logic [3:0] self_health,
    input  logic [3:0] self_shield,
    input  logic       self_facing,
    input  logic       opp_attack,
    input  logic [1:0] finish,
    output logic [6:0] cpu_inputs,
    output logic [2:0] state_dbg
);

    localparam int CW   = (DECISION_DIV > 1) ? $clog2(DECISION_DIV) : 1;
    localparam int HMAX = (ATTACK_HOLD > SHIELD_HOLD) ? ATTACK_HOLD : SHIELD_HOLD;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DECISION_DIV - 1);
    localparam logic [HW-1:0] A_HOLD   = HW'(ATTACK_HOLD);
    localparam logic [HW-1:0] S_HOLD   = HW'(SHIELD_HOLD);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [9:0]    RANGE    = 10'(ATTACK_RANGE);
    localparam logic [3:0]    LOW_H    = 4'(LOW_HEALTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [6:0]    out_q, out_d;
    state_e        state_q, state_d;
    logic          tick;
    logic [15:0]   lfsr_q;
    logic [9:0]    dx;
    logic          toward_left;
    logic          facing_ok;
    logic          in_range;
    logic          threat;
    logic          unused_ok;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (tick),
        .seed    (LFSR_SEED),
        .q       (lfsr_q)
    );

    assign dx          = (self_x >= opp_x) ? self_x - opp_x : opp_x - self_x;
    assign toward_left = (opp_x < self_x);
    assign facing_ok   = (self_facing == toward_left);
    assign in_range    = (dx <= RANGE);
    assign threat      = opp_attack && in_range;
    assign unused_ok   = ^{finish[1], lfsr_q[15:2]};

    // Decision-tick divider, free-running only while enabled
    always_comb begin
        tick  = enable && (cnt_q == CNT_LAST);
        cnt_d = cnt_q + CW'(1);
        if (!enable || tick) begin
            cnt_d = '0;
        end
    end

    // Next state and hold counter; decisions only on tick from free states
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!enable) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else if (finish[0]) begin
            state_d = ST_OVER;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_APPROACH, ST_RETREAT: begin
                    if (tick) begin
                        if (threat && self_shield != 4'd0) begin
                            state_d = ST_SHIELD;
                            hold_d  = S_HOLD;
                        end
`ifdef CPU_JUMP_EN
                        else if (threat && lfsr_q[0]) begin
                            state_d = ST_JUMP;
                            hold_d  = A_HOLD;
                        end
`endif
                        else if (in_range && !facing_ok) begin
                            state_d = ST_APPROACH;
                        end else if (in_range) begin
                            state_d = ST_ATK_PRESS;
                            hold_d  = A_HOLD;
                        end else if (self_health < LOW_H && lfsr_q[1:0] == 2'b00) begin
                            state_d = ST_RETREAT;
                        end else begin
                            state_d = ST_APPROACH;
                        end
                    end
                end
                ST_ATK_PRESS: begin
                    if (hold_q <= H_ONE) begin
                        state_d = ST_ATK_RELEASE;
                        hold_d  = A_HOLD;
                    end else begin
                        hold_d = hold_q - H_ONE;
                    end
                end
                ST_ATK_RELEASE: begin
                    if (hold_q <= H_ONE) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - H_ONE;
                    end
                end
                ST_SHIELD: begin
                    if (self_shield == 4'd0 || hold_q <= H_ONE) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - H_ONE;
                    end
                end
`ifdef CPU_JUMP_EN
                ST_JUMP: begin
                    if (hold_q <= H_ONE) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - H_ONE;
                    end
                end
`endif
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Button vector for the state being entered, registered with it
    always_comb begin
        out_d = '0;
        case (state_d)
            ST_APPROACH: begin
                if (toward_left) out_d[BTN_LEFT] = 1'b1;
                else             out_d[BTN_RIGHT] = 1'b1;
            end
            ST_RETREAT: begin
                if (toward_left) out_d[BTN_RIGHT] = 1'b1;
                else             out_d[BTN_LEFT] = 1'b1;
            end
            ST_ATK_PRESS: out_d[BTN_ATTACK] = 1'b1;
            ST_SHIELD:    out_d[BTN_SHIELD] = 1'b1;
`ifdef CPU_JUMP_EN
            ST_JUMP:      out_d[BTN_UP] = 1'b1;
`endif
            default:      out_d = '0;
        endcase
    end

    // Registers for divider, FSM, hold timer and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            hold_q  <= '0;
            state_q <= ST_IDLE;
            out_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign cpu_inputs = out_q;
    assign state_dbg  = state_q;

endmodule
